// File: rtl/fifo_param_if.sv
// FIFO port bundle: active-low write/read/clear strobes in, data and status out.
// Build option FIFO_PARAM_FWFT_EN (see fifo_param.sv) changes only data_o timing.
interface fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
);
  localparam int CW = $clog2(DEPTH + 1);

  // Strobe semantics: n_we_i=0 offers data_i for one edge and is taken only if
  // the FIFO has room (or a read is taken the same edge); n_re_i=0 pops only if
  // count_o>0. A refused strobe sets the matching sticky error flag instead.
  logic [WIDTH-1:0] data_i;
  logic             n_we_i;
  logic             n_re_i;
  logic             n_clr_i;
  logic [WIDTH-1:0] data_o;
  logic             p_empty_o;
  logic             p_full_o;
  logic             p_aempty_o;
  logic             p_afull_o;
  logic [CW-1:0]    count_o;
  logic             p_ovf_o;
  logic             p_udf_o;

  modport slave (
    input  data_i, n_we_i, n_re_i, n_clr_i,
    output data_o, p_empty_o, p_full_o, p_aempty_o, p_afull_o,
           count_o, p_ovf_o, p_udf_o
  );

  modport master (
    output data_i, n_we_i, n_re_i, n_clr_i,
    input  data_o, p_empty_o, p_full_o, p_aempty_o, p_afull_o,
           count_o, p_ovf_o, p_udf_o
  );
endinterface

// File: rtl/fifo_param.sv
// Synchronous FIFO, any DEPTH (no spare slot), count-derived flags, sticky ovf/udf.
// `define FIFO_PARAM_FWFT_EN for first-word-fall-through data_o; default is registered read.
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 128,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic        clk,
  input  logic        rst,
  fifo_param_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf;
  logic             udf;
  logic             rd_acc;
  logic             wr_acc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO still takes a write when the same edge pops an entry.
  assign rd_acc = !bus.n_re_i && (count != '0);
  assign wr_acc = !bus.n_we_i && ((count != FULL_C) || rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (!bus.n_clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (!bus.n_we_i && !wr_acc) ovf <= 1'b1;
      if (!bus.n_re_i && !rd_acc) udf <= 1'b1;
    end
  end

  // Storage is never cleared; only the pointers forget it.
  always_ff @(posedge clk) begin
    if (!rst && bus.n_clr_i && wr_acc) mem[wr_ptr] <= bus.data_i;
  end

`ifdef FIFO_PARAM_FWFT_EN
  assign bus.data_o = (count != '0) ? mem[rd_ptr] : '0;
`else
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 data_q <= '0;
    else if (!bus.n_clr_i)   data_q <= '0;
    else if (rd_acc)         data_q <= mem[rd_ptr];
  end

  assign bus.data_o = data_q;
`endif

  assign bus.count_o    = count;
  assign bus.p_empty_o  = (count == '0);
  assign bus.p_full_o   = (count == FULL_C);
  assign bus.p_aempty_o = (count <= AE_C);
  assign bus.p_afull_o  = (count >= AF_C);
  assign bus.p_ovf_o    = ovf;
  assign bus.p_udf_o    = udf;
endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param (WIDTH=8, DEPTH=4, AF=3, AE=1): constant vector table,
// hand sequences for wrap/clear/reset corners, and random traffic against a queue model.
module tb_fifo_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;
  localparam int NV    = 25;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: queue contents, last popped word, sticky errors.
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_udf;

  typedef struct {
    logic       we_n;
    logic       re_n;
    logic       clr_n;
    logic [7:0] din;
    int         e_count;
    logic       e_full;
    logic       e_afull;
    logic [7:0] e_data;
    logic       e_ovf;
    logic       e_udf;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_data();
`ifdef FIFO_PARAM_FWFT_EN
    return (exp_q.size() > 0) ? exp_q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_edge(input logic we_n, input logic re_n, input logic clr_n,
                            input logic [WIDTH-1:0] d);
    logic rd_ok;
    logic wr_ok;
    logic [WIDTH-1:0] head;
    if (!clr_n) begin
      model_reset();
    end else begin
      rd_ok = !re_n && (exp_q.size() > 0);
      wr_ok = !we_n && ((exp_q.size() < DEPTH) || rd_ok);
      if (rd_ok) begin
        head   = exp_q.pop_front();
        m_dout = head;
      end
      if (wr_ok) exp_q.push_back(d);
      if (!we_n && !wr_ok) m_ovf = 1'b1;
      if (!re_n && !rd_ok) m_udf = 1'b1;
    end
  endtask

  task automatic check_model();
    int n;
    n = exp_q.size();
    chk("count",  32'(bus.count_o),    32'(n));
    chk("empty",  32'(bus.p_empty_o),  32'(n == 0));
    chk("full",   32'(bus.p_full_o),   32'(n == DEPTH));
    chk("aempty", 32'(bus.p_aempty_o), 32'(n <= AE));
    chk("afull",  32'(bus.p_afull_o),  32'(n >= AF));
    chk("data",   32'(bus.data_o),     32'(model_data()));
    chk("ovf",    32'(bus.p_ovf_o),    32'(m_ovf));
    chk("udf",    32'(bus.p_udf_o),    32'(m_udf));
  endtask

  task automatic step(input logic we_n, input logic re_n, input logic clr_n,
                      input logic [WIDTH-1:0] d);
    @(negedge clk);
    bus.n_we_i  = we_n;
    bus.n_re_i  = re_n;
    bus.n_clr_i = clr_n;
    bus.data_i  = d;
    model_edge(we_n, re_n, clr_n, d);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.n_we_i  = 1'b1;
    bus.n_re_i  = 1'b1;
    bus.n_clr_i = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_count",  32'(bus.count_o),    32'd0);
    chk("rst_empty",  32'(bus.p_empty_o),  32'd1);
    chk("rst_aempty", 32'(bus.p_aempty_o), 32'd1);
    chk("rst_full",   32'(bus.p_full_o),   32'd0);
    chk("rst_afull",  32'(bus.p_afull_o),  32'd0);
    chk("rst_data",   32'(bus.data_o),     32'h00);
    chk("rst_ovf",    32'(bus.p_ovf_o),    32'd0);
    chk("rst_udf",    32'(bus.p_udf_o),    32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.n_we_i  = 1'b1;
    bus.n_re_i  = 1'b1;
    bus.n_clr_i = 1'b1;
    bus.data_i  = '0;
    model_reset();

    //           we   re   clr  din    cnt full af   data   ovf  udf
    vecs[0]  = '{1'b0,1'b1,1'b1,8'h11, 1, 1'b0,1'b0,8'h00, 1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b1,8'h22, 2, 1'b0,1'b0,8'h00, 1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b1,8'h33, 3, 1'b0,1'b1,8'h00, 1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b1,8'h44, 4, 1'b1,1'b1,8'h00, 1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b1,8'h55, 4, 1'b1,1'b1,8'h00, 1'b1,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b1,8'h00, 3, 1'b0,1'b1,8'h11, 1'b1,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b1,8'h00, 2, 1'b0,1'b0,8'h22, 1'b1,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b1,8'h00, 1, 1'b0,1'b0,8'h33, 1'b1,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b1,8'h00, 0, 1'b0,1'b0,8'h44, 1'b1,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0,8'h00, 0, 1'b0,1'b0,8'h00, 1'b0,1'b0};
    vecs[10] = '{1'b0,1'b1,1'b1,8'h11, 1, 1'b0,1'b0,8'h00, 1'b0,1'b0};
    vecs[11] = '{1'b0,1'b1,1'b1,8'h22, 2, 1'b0,1'b0,8'h00, 1'b0,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b1,8'h33, 3, 1'b0,1'b1,8'h00, 1'b0,1'b0};
    vecs[13] = '{1'b0,1'b1,1'b1,8'h44, 4, 1'b1,1'b1,8'h00, 1'b0,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b1,8'h66, 4, 1'b1,1'b1,8'h11, 1'b0,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b1,8'h00, 3, 1'b0,1'b1,8'h22, 1'b0,1'b0};
    vecs[16] = '{1'b1,1'b0,1'b1,8'h00, 2, 1'b0,1'b0,8'h33, 1'b0,1'b0};
    vecs[17] = '{1'b1,1'b0,1'b1,8'h00, 1, 1'b0,1'b0,8'h44, 1'b0,1'b0};
    vecs[18] = '{1'b1,1'b0,1'b1,8'h00, 0, 1'b0,1'b0,8'h66, 1'b0,1'b0};
    vecs[19] = '{1'b1,1'b0,1'b1,8'h00, 0, 1'b0,1'b0,8'h66, 1'b0,1'b1};
    vecs[20] = '{1'b0,1'b1,1'b0,8'h77, 0, 1'b0,1'b0,8'h00, 1'b0,1'b0};
    vecs[21] = '{1'b1,1'b0,1'b1,8'h00, 0, 1'b0,1'b0,8'h00, 1'b0,1'b1};
    vecs[22] = '{1'b0,1'b0,1'b1,8'h88, 1, 1'b0,1'b0,8'h00, 1'b0,1'b1};
    vecs[23] = '{1'b1,1'b0,1'b1,8'h00, 0, 1'b0,1'b0,8'h88, 1'b0,1'b1};
    vecs[24] = '{1'b1,1'b1,1'b0,8'h00, 0, 1'b0,1'b0,8'h00, 1'b0,1'b0};

    do_reset();

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].we_n, vecs[i].re_n, vecs[i].clr_n, vecs[i].din);
      chk($sformatf("vec%0d_count", i), 32'(bus.count_o),  32'(vecs[i].e_count));
      chk($sformatf("vec%0d_full", i),  32'(bus.p_full_o), 32'(vecs[i].e_full));
      chk($sformatf("vec%0d_afull", i), 32'(bus.p_afull_o), 32'(vecs[i].e_afull));
      chk($sformatf("vec%0d_ovf", i),   32'(bus.p_ovf_o),  32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_udf", i),   32'(bus.p_udf_o),  32'(vecs[i].e_udf));
`ifndef FIFO_PARAM_FWFT_EN
      chk($sformatf("vec%0d_data", i),  32'(bus.data_o),   32'(vecs[i].e_data));
`endif
    end

    // Pointer wrap: advance both pointers to 3, then write across the wrap.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'(i + 1));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hA1);
    step(1'b0, 1'b1, 1'b1, 8'hA2);
    step(1'b0, 1'b1, 1'b1, 8'hA3);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] want;
      want = 8'hA1 + 8'(i);
`ifdef FIFO_PARAM_FWFT_EN
      chk("wrap_head", 32'(bus.data_o), 32'(want));
      step(1'b1, 1'b0, 1'b1, 8'h00);
`else
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("wrap_data", 32'(bus.data_o), 32'(want));
`endif
    end
    chk("wrap_empty", 32'(bus.p_empty_o), 32'd1);

`ifdef FIFO_PARAM_FWFT_EN
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    chk("fwft_head", 32'(bus.data_o), 32'hA5);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("fwft_zero", 32'(bus.data_o), 32'h00);
    chk("fwft_empty", 32'(bus.p_empty_o), 32'd1);
`endif

    // Reset mid-operation discards contents; next access starts again at slot 0.
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 1'b1, 8'h4D);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h00);

    // Random traffic; clear is rare so the FIFO reaches full and empty often.
    for (int i = 0; i < 400; i++) begin
      logic we_n;
      logic re_n;
      logic clr_n;
      we_n  = ($urandom_range(0, 9) < 5) ? 1'b0 : 1'b1;
      re_n  = ($urandom_range(0, 9) < 5) ? 1'b0 : 1'b1;
      clr_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      step(we_n, re_n, clr_n, 8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 128, storage entries (2..256, any value, not limited to powers of two).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost-full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold in entries.
REQ-005 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port data_i  input  WIDTH  write data.
REQ-008 SHALL have port n_we_i  input  1  write strobe, active-low.
REQ-009 SHALL have port n_re_i  input  1  read strobe, active-low.
REQ-010 SHALL have port n_clr_i  input  1  synchronous clear, active-low.
REQ-011 SHALL have port data_o  output  WIDTH  read data.
REQ-012 SHALL have ports p_empty_o, p_full_o, p_aempty_o, p_afull_o  output  1 each  status flags, active-high.
REQ-013 SHALL have port count_o  output  CW  fill level; CW = clog2(DEPTH+1).
REQ-014 SHALL have ports p_ovf_o, p_udf_o  output  1 each  sticky overflow and underflow flags.

Function
REQ-015 SHALL store exactly DEPTH entries; there SHALL be no sacrificial empty slot.
REQ-016 SHALL derive flags from a registered count: empty = (count==0), full = (count==DEPTH), aempty = (count<=AE_LEVEL), afull = (count>=AF_LEVEL).
REQ-017 SHALL accept a read when n_re_i=0 and count>0.
REQ-018 SHALL accept a write when n_we_i=0 and either count<DEPTH or a read is accepted in the same cycle.
REQ-019 SHALL apply count changes per cycle: write only -> +1; read only -> -1; both accepted -> unchanged.
REQ-020 SHALL advance each pointer by 1 per accepted access, wrapping from DEPTH-1 to 0.
REQ-021 SHALL, on a simultaneous write and read while empty, reject the read, accept the write and set p_udf_o.
REQ-022 SHALL set p_ovf_o on the edge of a rejected write, and p_udf_o on the edge of a rejected read; both flags SHALL hold until n_clr_i or rst.
REQ-023 SHALL leave the pointers, count, memory and data_o unchanged on a rejected access.
REQ-024 SHALL, on a rising edge with n_clr_i=0, zero the pointers, count, data_o, p_ovf_o and p_udf_o, with priority over any simultaneous read or write.
REQ-025 SHALL NOT clear memory contents on n_clr_i or rst.

Reset
REQ-026 SHALL, while rst=1, force pointers=0, count_o=0, data_o=0, p_empty_o=1, p_aempty_o=1, p_full_o=0, p_afull_o=0 (given AF_LEVEL>0), p_ovf_o=0 and p_udf_o=0, independent of clk.
REQ-027 SHALL require rst deassertion synchronous to clk; synchronising rst is the integrator's responsibility.
REQ-028 SHALL discard any in-flight access when rst asserts mid-operation; the next access after reset SHALL use address 0.

Configuration
REQ-029 SHALL support macro FIFO_PARAM_FWFT_EN.
REQ-030 SHALL, without FIFO_PARAM_FWFT_EN, drive data_o from a register loaded with memory[rd_ptr] on the edge where a read is accepted (1-cycle latency); data_o SHALL hold otherwise.
REQ-031 SHALL, with FIFO_PARAM_FWFT_EN, drive data_o with memory[rd_ptr] whenever count>0 and with 0 when empty; the head entry SHALL be visible on the cycle after it is written, and a read SHALL pop it. Flags, count and error behaviour SHALL be identical in both modes.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-032 SHALL cover: assert rst -> count_o=0, p_empty_o=1, p_aempty_o=1, p_full_o=0, data_o=0x00.
REQ-033 SHALL cover: write 0x11,0x22,0x33,0x44 -> p_afull_o=1 after the 3rd write, p_full_o=1 and count_o=4 after the 4th; a 5th write of 0x55 -> count_o=4 and p_ovf_o=1; four reads -> data_o=0x11,0x22,0x33,0x44, each 1 cycle after its strobe (non-FWFT).
REQ-034 SHALL cover: while full, simultaneous write 0x66 and read -> count_o stays 4, p_ovf_o stays 0; draining the FIFO then returns 0x22,0x33,0x44,0x66.
REQ-035 SHALL cover: write 3, read 3, write 0xA1,0xA2,0xA3 (pointer wrap) -> reads return 0xA1,0xA2,0xA3 in order, and p_empty_o=1 at the end.
REQ-036 SHALL cover: read while empty -> p_udf_o=1 with data_o unchanged; then n_clr_i=0 for one cycle together with a write of 0x77 -> count_o=0, p_udf_o=0, p_ovf_o=0, and the write is discarded.
REQ-037 SHALL cover: with FIFO_PARAM_FWFT_EN, write 0xA5 to an empty FIFO -> data_o=0xA5 on the next cycle with no read strobe; after reading it -> data_o=0x00 and p_empty_o=1.
